// File: rtl/sha2_block_engine.sv
`default_nettype none
// ============================================================================
// Module   : sha2_block_engine
// Brief    : SHA-224/SHA-256 block compression engine with internal schedule,
//            K table and multi-block hash chaining; 1, 2 or 4 rounds per clock.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_block_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit RESET_TO_IV      = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid_i,
    output logic         blk_ready_o,
    input  logic [511:0] blk_i,
    input  logic         first_i,
    input  logic         last_i,
    input  logic         mode_224_i,
    output logic         blk_done_o,
    output logic         digest_valid_o,
    output logic [255:0] digest_o
);

    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rounds
            $error("sha2_block_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         c_R    = ROUNDS_PER_CYCLE;
    localparam logic [6:0] c_STEP = 7'(ROUNDS_PER_CYCLE);

    localparam logic [255:0] c_IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] c_IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_UPDATE = 2'd2} state_t;

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] f_round(input logic [255:0] s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (f_rotr(e, 6) ^ f_rotr(e, 11) ^ f_rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (f_rotr(a, 2) ^ f_rotr(a, 13) ^ f_rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    state_t        r_state;
    logic [6:0]    r_cnt;
    logic [31:0]   r_w [0:15];
    logic [255:0]  r_work;
    logic [255:0]  r_h;
    logic          r_mode;
    logic          r_last;
    logic          r_ready;
    logic          r_done;
    logic          r_dvalid;
    logic [255:0]  r_digest;

    logic [31:0]   w_ext [0:15+c_R];
    logic [255:0]  w_st;
    logic [5:0]    w_kidx;
    logic [255:0]  w_h_new;
    logic [255:0]  w_iv;

    assign w_iv = mode_224_i ? c_IV_224 : c_IV_256;

    // Words generated late in a block extend past t=63; they are never consumed.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int j = 0; j < c_R; j++) begin
            w_ext[16+j] = (f_rotr(w_ext[14+j], 17) ^ f_rotr(w_ext[14+j], 19) ^ (w_ext[14+j] >> 10))
                        + w_ext[9+j]
                        + (f_rotr(w_ext[1+j], 7) ^ f_rotr(w_ext[1+j], 18) ^ (w_ext[1+j] >> 3))
                        + w_ext[j];
        end
        w_st   = r_work;
        w_kidx = r_cnt[5:0];
        for (int j = 0; j < c_R; j++) begin
            w_st   = f_round(w_st, c_K[w_kidx], w_ext[j]);
            w_kidx = w_kidx + 6'd1;
        end
    end

    always_comb begin
        w_h_new = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_new[32*i +: 32] = r_h[32*i +: 32] + r_work[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_work   <= '0;
            r_h      <= RESET_TO_IV ? c_IV_256 : '0;
            r_mode   <= 1'b0;
            r_last   <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_dvalid <= 1'b0;
            r_digest <= '0;
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (blk_valid_i && r_ready) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= blk_i[511-32*i -: 32];
                        end
                        r_last <= last_i;
                        if (first_i) begin
                            r_mode <= mode_224_i;
                            r_h    <= w_iv;
                            r_work <= w_iv;
                        end else begin
                            r_work <= r_h;
                        end
                        r_dvalid <= 1'b0;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_work <= w_st;
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_ext[i+c_R];
                    end
                    r_cnt <= r_cnt + c_STEP;
                    if (r_cnt == 7'd64 - c_STEP) begin
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_h     <= w_h_new;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    if (r_last) begin
                        r_dvalid <= 1'b1;
                        r_digest <= r_mode ? {w_h_new[255:32], 32'h0} : w_h_new;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign blk_ready_o    = r_ready;
    assign blk_done_o     = r_done;
    assign digest_valid_o = r_dvalid;
    assign digest_o       = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_sha2_block_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_block_engine
// Brief    : Directed bench for sha2_block_engine at 1, 2 and 4 rounds/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_block_engine;

    localparam logic [511:0] c_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] c_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] c_TWO1  = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] c_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] c_D_ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] c_D_ABC224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] c_D_TWO    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] c_D_EMPTY  = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld [3];
    logic [511:0]  blk = '0;
    logic          first = 1'b0;
    logic          last = 1'b0;
    logic          mode = 1'b0;
    logic          rdy [3];
    logic          done [3];
    logic          dv [3];
    logic [255:0]  dig [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha2_block_engine #(.ROUNDS_PER_CYCLE(1), .RESET_TO_IV(1'b0)) u_r1 (
        .clk(clk), .rst_n(rst_n), .blk_valid_i(vld[0]), .blk_ready_o(rdy[0]), .blk_i(blk),
        .first_i(first), .last_i(last), .mode_224_i(mode), .blk_done_o(done[0]),
        .digest_valid_o(dv[0]), .digest_o(dig[0])
    );
    sha2_block_engine #(.ROUNDS_PER_CYCLE(2), .RESET_TO_IV(1'b0)) u_r2 (
        .clk(clk), .rst_n(rst_n), .blk_valid_i(vld[1]), .blk_ready_o(rdy[1]), .blk_i(blk),
        .first_i(first), .last_i(last), .mode_224_i(mode), .blk_done_o(done[1]),
        .digest_valid_o(dv[1]), .digest_o(dig[1])
    );
    sha2_block_engine #(.ROUNDS_PER_CYCLE(4), .RESET_TO_IV(1'b1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .blk_valid_i(vld[2]), .blk_ready_o(rdy[2]), .blk_i(blk),
        .first_i(first), .last_i(last), .mode_224_i(mode), .blk_done_o(done[2]),
        .digest_valid_o(dv[2]), .digest_o(dig[2])
    );

    typedef struct {
        int           d;
        logic [511:0] b;
        logic         f;
        logic         l;
        logic         m;
        logic         edv;
        logic [255:0] edig;
        int           elat;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_block(input int d, input logic [511:0] b, input logic f, input logic l,
                             input logic m, output int lat);
        blk   = b;
        first = f;
        last  = l;
        mode  = m;
        vld[d] = 1'b1;
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        chk("busy_after_accept", 256'(rdy[d]), 256'd0);
        chk("dv_cleared_at_accept", 256'(dv[d]), 256'd0);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done[d]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic chk_reset(input int d);
        chk("reset_ready", 256'(rdy[d]), 256'd1);
        chk("reset_done", 256'(done[d]), 256'd0);
        chk("reset_dv", 256'(dv[d]), 256'd0);
        chk("reset_digest", dig[d], 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy_err;

        for (int i = 0; i < 3; i++) vld[i] = 1'b0;

        tv[0] = '{d: 2, b: c_ABC,   f: 1'b0, l: 1'b1, m: 1'b0, edv: 1'b1, edig: c_D_ABC256, elat: 17};
        tv[1] = '{d: 0, b: c_ABC,   f: 1'b1, l: 1'b1, m: 1'b0, edv: 1'b1, edig: c_D_ABC256, elat: 65};
        tv[2] = '{d: 0, b: c_ABC,   f: 1'b1, l: 1'b1, m: 1'b1, edv: 1'b1, edig: c_D_ABC224, elat: 65};
        tv[3] = '{d: 0, b: c_TWO1,  f: 1'b1, l: 1'b0, m: 1'b0, edv: 1'b0, edig: c_D_ABC224, elat: 65};
        tv[4] = '{d: 0, b: c_TWO2,  f: 1'b0, l: 1'b1, m: 1'b1, edv: 1'b1, edig: c_D_TWO,    elat: 65};
        tv[5] = '{d: 1, b: c_EMPTY, f: 1'b1, l: 1'b1, m: 1'b0, edv: 1'b1, edig: c_D_EMPTY,  elat: 33};
        tv[6] = '{d: 2, b: c_EMPTY, f: 1'b1, l: 1'b1, m: 1'b0, edv: 1'b1, edig: c_D_EMPTY,  elat: 17};
        tv[7] = '{d: 0, b: c_TWO1,  f: 1'b1, l: 1'b0, m: 1'b0, edv: 1'b0, edig: c_D_TWO,    elat: 65};
        tv[8] = '{d: 0, b: c_ABC,   f: 1'b1, l: 1'b1, m: 1'b0, edv: 1'b1, edig: c_D_ABC256, elat: 65};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_block(tv[i].d, tv[i].b, tv[i].f, tv[i].l, tv[i].m, lat);
            chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(tv[i].elat));
            chk($sformatf("vec%0d_ready_at_done", i), 256'(rdy[tv[i].d]), 256'd1);
            chk($sformatf("vec%0d_dv", i), 256'(dv[tv[i].d]), 256'(tv[i].edv));
            chk($sformatf("vec%0d_digest", i), dig[tv[i].d], tv[i].edig);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), 256'(done[tv[i].d]), 256'd0);
            chk($sformatf("vec%0d_digest_hold", i), dig[tv[i].d], tv[i].edig);
        end

        // Valid held high with scrambled data while the engine is busy.
        blk    = c_ABC;
        first  = 1'b1;
        last   = 1'b1;
        mode   = 1'b0;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        busy_err = 0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            blk   = {16{$urandom}};
            first = 1'($urandom_range(0, 1));
            last  = 1'($urandom_range(0, 1));
            mode  = 1'($urandom_range(0, 1));
            if (rdy[0]) busy_err++;
            @(posedge clk);
            #1;
            if (done[0]) begin
                lat = n;
                break;
            end
        end
        vld[0] = 1'b0;
        chk("bp_latency", 256'(lat), 256'd65);
        chk("bp_no_ready_while_busy", 256'(busy_err), 256'd0);
        chk("bp_digest", dig[0], c_D_ABC256);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_second_accept", 256'(dv[0]), 256'd1);

        // Abort in the middle of a block.
        blk    = c_ABC;
        first  = 1'b1;
        last   = 1'b1;
        mode   = 1'b0;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk_reset(0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset(0);
        run_block(0, c_ABC, 1'b1, 1'b1, 1'b0, lat);
        chk("post_abort_latency", 256'(lat), 256'd65);
        chk("post_abort_dv", 256'(dv[0]), 256'd1);
        chk("post_abort_digest", dig[0], c_D_ABC256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha2_block_engine.md
Name: sha2_block_engine

Overview:
- Parametrised SHA-224/SHA-256 compression engine. It is the successor of the single-round hash core.
- Accepts a full pre-padded 512-bit block over a valid/ready handshake. It expands the message schedule internally, holds the K constants internally, and runs 64 rounds at a configurable number of rounds per cycle.
- Chains the intermediate hash across blocks of a multi-block message.
- Sits between the padding unit and the digest output register / host interface.

Parameters:
- ROUNDS_PER_CYCLE, 1, rounds unrolled per clock. Legal values are 1, 2, 4; any other value is an elaboration error.
- RESET_TO_IV, 0, reset value of the internal H registers: 0 means all-zero, 1 means the SHA-256 IV.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- blk_valid_i  in  1  block present on blk_i.
- blk_ready_o  out  1  engine can accept a block.
- blk_i  in  512  padded block. W0 = blk_i[511:480], W15 = blk_i[31:0]. Words are big-endian.
- first_i  in  1  this block starts a new message; load IV before compressing. Sampled at accept.
- last_i  in  1  this block ends the message. Sampled at accept.
- mode_224_i  in  1  1 = SHA-224 IV/truncation, 0 = SHA-256. Sampled only when first_i=1 at accept.
- blk_done_o  out  1  one-cycle pulse: a block's compression is complete.
- digest_valid_o  out  1  level: digest_o holds a final message digest.
- digest_o  out  256  H0..H7, with H0 in [255:224]. In SHA-224 mode, [31:0] = 0.

Behaviour:
- Reset values: blk_ready_o=1, blk_done_o=0, digest_valid_o=0, digest_o=0. a..h=0, round counter=0, mode latch=0, last latch=0. H = 0 or the SHA-256 IV per RESET_TO_IV.
- Reset asserted mid-block aborts immediately. Nothing partial is retained.
- States: IDLE, ROUND, UPDATE.
  - IDLE: blk_ready_o=1. On blk_valid_i & blk_ready_o (accept edge):
    - latch W0..W15 into a 16-word schedule window;
    - latch last_i;
    - if first_i: latch mode_224_i, load H and a..h from the IV of that mode;
    - else: load a..h from the current H;
    - clear digest_valid_o; counter=0; go to ROUND.
  - ROUND: blk_ready_o=0. Each edge performs ROUNDS_PER_CYCLE standard SHA-2 rounds, consuming K[t] and W[t] for t = counter .. counter+R-1.
    - Window advances by R words. New W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], all mod 2^32.
    - counter += R. After 64/R edges (counter reaches 64), go to UPDATE.
  - UPDATE: one edge. H[i] <= H[i] + working var[i], mod 2^32.
    - blk_done_o=1 for the following cycle.
    - If the latched last=1: digest_o is updated from the new H, and digest_valid_o=1 from that cycle.
    - Return to IDLE. blk_ready_o=1 in the same cycle blk_done_o is high.
- Latency: accept edge to blk_done_o/digest_valid_o visible = 64/ROUNDS_PER_CYCLE + 1 edges (65 / 33 / 17).
- Throughput: one block per 64/R + 2 cycles, including the IDLE accept cycle.
- IV values:
  - SHA-256: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - SHA-224: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- K[0..63] is the standard FIPS 180-4 table, implemented as an internal constant array indexed by counter+j.
- Mode latch persists for all chained blocks. mode_224_i on a non-first block is ignored.
- blk_valid_i while busy: no accept. Upstream must hold blk_i and its flags stable until accept.
- first_i=1 arriving mid-message: restarts with the IV. The prior chain is discarded and no error is flagged.
- first_i=0 after reset with no prior block: chains from the reset value of H. This is defined behaviour, not an error.
- digest_valid_o and digest_o stay stable until the next accept edge, or until reset.
- Non-last blocks never update digest_o.
- All additions wrap mod 2^32. No saturation, no carries across words.

Test Plan:
- Digest vectors below are listed H0..H7, i.e. digest_o MSB first.
- "abc", SHA-256 single block (first=last=1, mode=0), R=1 → blk_done_o exactly 65 edges after accept. digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. digest_valid_o=1.
- Same block, mode_224=1 → digest_o = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 (first=1, last=0) → blk_done_o pulse, digest_valid_o stays 0;
  - block 2 (first=0, last=1, mode_224_i=1, which must be ignored) → digest_o = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Empty message at R=2 and R=4 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Latency is 33 and 17 edges respectively.
- Back-pressure and abort:
  - blk_valid_i held high with changing blk_i while in ROUND → no second accept, result unaffected;
  - rst_n pulsed at round 30 → all outputs return to reset values, blk_ready_o=1;
  - then "abc" gives the correct digest.
- Restart: first=1 block of "abc" issued after a first=1/last=0 block → digest equals the single-block "abc" digest.
